// File: rtl/recv_check_pkg.sv
// Shared definitions for the switch send/receive test: header layout,
// error bit positions, receive FSM states and the payload pattern.
package recv_check_pkg;

  localparam int ERR_W       = 5;
  localparam int ERR_FRAMING = 0;
  localparam int ERR_DEST    = 1;
  localparam int ERR_LENGTH  = 2;
  localparam int ERR_DATA    = 3;
  localparam int ERR_TIMEOUT = 4;

  localparam logic [ERR_W-1:0] ERR_M_FRAMING = 5'b00001;
  localparam logic [ERR_W-1:0] ERR_M_DEST    = 5'b00010;
  localparam logic [ERR_W-1:0] ERR_M_LENGTH  = 5'b00100;
  localparam logic [ERR_W-1:0] ERR_M_DATA    = 5'b01000;
  localparam logic [ERR_W-1:0] ERR_M_TIMEOUT = 5'b10000;

  // Header: dest at bit 0, then priority, then length; src sits in the top bits.
  localparam int HDR_DEST_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  function automatic int hdr_prio_lsb(input int width_sel);
    return HDR_DEST_LSB + width_sel;
  endfunction

  function automatic int hdr_len_lsb(input int width_sel, input int width_priority);
    return HDR_DEST_LSB + width_sel + width_priority;
  endfunction

  // Payload word k: {src, zero fill, k}; caller truncates to its data width.
  function automatic logic [63:0] expected_word(input logic [63:0] src,
                                                input logic [63:0] k,
                                                input int          data_width,
                                                input int          width_sel,
                                                input int          width_length);
    logic [63:0] src_m;
    logic [63:0] k_m;
    src_m = src & ((64'd1 << width_sel) - 64'd1);
    k_m   = k & ((64'd1 << width_length) - 64'd1);
    return (src_m << (data_width - width_sel)) | k_m;
  endfunction

endpackage

// File: rtl/recv_check_if.sv
// Read side of one switch egress port: sop/eop pulses plus valid-qualified data.
interface recv_check_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  rd_sop;
  logic                  rd_eop;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output rd_sop, output rd_eop, output rd_vld, output rd_data);
  modport slave  (input  rd_sop, input  rd_eop, input  rd_vld, input  rd_data);

endinterface

// File: rtl/recv_check_sat_counter.sv
// Statistics counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Count register with saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_ZERO;
    end else if (clr) begin
      cnt <= CNT_ZERO;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/recv_check.sv
// Egress-port receive checker: parses header, checks framing, destination,
// length and payload pattern, and keeps sticky flags and saturating counters.
module recv_check
  import recv_check_pkg::*;
#(
  parameter  int RX_PORT         = 0,
  parameter  int PORT_NUB        = 4,
  parameter  int DATA_WIDTH      = 32,
  parameter  int DATA_LENGTH_MAX = 256,
  parameter  int PRIORITY        = 8,
  parameter  int TIMEOUT_CYC     = 4096,
  parameter  int CNT_WIDTH       = 32,
  localparam int WIDTH_SEL       = $clog2(PORT_NUB),
  localparam int WIDTH_LENGTH    = $clog2(DATA_LENGTH_MAX),
  localparam int WIDTH_PRIORITY  = $clog2(PRIORITY)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  recv_check_if.slave               rd,
  output logic                      pkt_done,
  output logic                      pkt_err,
  output logic [ERR_W-1:0]          err_flags,
  output logic [CNT_WIDTH-1:0]      pkt_ok_cnt,
  output logic [CNT_WIDTH-1:0]      pkt_err_cnt,
  output logic [CNT_WIDTH-1:0]      word_cnt,
  output logic [WIDTH_SEL-1:0]      last_src,
  output logic [WIDTH_PRIORITY-1:0] last_prio
);

  localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int PRIO_LSB = hdr_prio_lsb(WIDTH_SEL);
  localparam int LEN_LSB  = hdr_len_lsb(WIDTH_SEL, WIDTH_PRIORITY);
  localparam int CTX_W    = WIDTH_SEL + WIDTH_PRIORITY + 2 * WIDTH_LENGTH + ERR_W;

  localparam logic [WIDTH_SEL-1:0]    RX_SEL    = WIDTH_SEL'(RX_PORT);
  localparam logic [TMO_W-1:0]        TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]        TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]        TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_LENGTH-1:0] LEN_ZERO  = {WIDTH_LENGTH{1'b0}};
  localparam logic [WIDTH_LENGTH-1:0] LEN_ONE   = {{(WIDTH_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]        ERR_NONE  = {ERR_W{1'b0}};
  localparam logic [CTX_W-1:0]        CTX_ZERO  = {CTX_W{1'b0}};

  state_t                    st_r,   st_s;
  logic [WIDTH_SEL-1:0]      src_r,  src_s;
  logic [WIDTH_PRIORITY-1:0] prio_r, prio_s;
  logic [WIDTH_LENGTH-1:0]   len_r,  len_s;
  logic [WIDTH_LENGTH-1:0]   k_r,    k_s;
  logic [ERR_W-1:0]          perr_r, perr_s;
  logic [TMO_W-1:0]          tmo_r,  tmo_s;

  logic                      close_s;
  logic [ERR_W-1:0]          close_err_s;
  logic [ERR_W-1:0]          flag_set_s;
  logic                      word_inc_s;
  logic                      ok_inc_s;
  logic                      bad_inc_s;

  logic [WIDTH_SEL-1:0]      hdr_dest_s;
  logic [WIDTH_SEL-1:0]      hdr_src_s;
  logic [WIDTH_PRIORITY-1:0] hdr_prio_s;
  logic [WIDTH_LENGTH-1:0]   hdr_len_s;
  logic [DATA_WIDTH-1:0]     exp_word_s;

  assign hdr_dest_s = rd.rd_data[HDR_DEST_LSB +: WIDTH_SEL];
  assign hdr_prio_s = rd.rd_data[PRIO_LSB +: WIDTH_PRIORITY];
  assign hdr_len_s  = rd.rd_data[LEN_LSB +: WIDTH_LENGTH];
  assign hdr_src_s  = rd.rd_data[DATA_WIDTH-1 -: WIDTH_SEL];
  assign exp_word_s = DATA_WIDTH'(expected_word(64'(src_r), 64'(k_r), DATA_WIDTH,
                                                WIDTH_SEL, WIDTH_LENGTH));

  assign ok_inc_s  = close_s && (close_err_s == ERR_NONE);
  assign bad_inc_s = close_s && (close_err_s != ERR_NONE);

  // Next-state, per-packet error accumulation and close events.
  always_comb begin
    st_s        = st_r;
    src_s       = src_r;
    prio_s      = prio_r;
    len_s       = len_r;
    k_s         = k_r;
    perr_s      = perr_r;
    tmo_s       = TMO_ZERO;
    close_s     = 1'b0;
    close_err_s = ERR_NONE;
    word_inc_s  = 1'b0;
    flag_set_s  = (rd.rd_sop && rd.rd_vld) ? ERR_M_FRAMING : ERR_NONE;
    case (st_r)
      IDLE: begin
        if (rd.rd_sop) begin
          st_s = HDR;
          {src_s, prio_s, len_s, k_s, perr_s} = CTX_ZERO;
        end else if (rd.rd_eop || rd.rd_vld) begin
          flag_set_s = flag_set_s | ERR_M_FRAMING;
        end else begin
          st_s = IDLE;
        end
      end
      HDR, PAY: begin
        if (rd.rd_sop) begin
          // Resync: the open packet closes bad, the new one starts clean.
          close_s     = 1'b1;
          close_err_s = perr_r | ERR_M_FRAMING;
          st_s        = HDR;
          {src_s, prio_s, len_s, k_s, perr_s} = CTX_ZERO;
        end else if (rd.rd_eop) begin
          close_s = 1'b1;
          st_s    = IDLE;
          if (st_r == HDR) begin
            close_err_s = perr_r | ERR_M_FRAMING;
          end else if (k_r != len_r) begin
            close_err_s = perr_r | ERR_M_LENGTH;
          end else begin
            close_err_s = perr_r;
          end
        end else if (rd.rd_vld) begin
          if (st_r == HDR) begin
            src_s  = hdr_src_s;
            prio_s = hdr_prio_s;
            len_s  = hdr_len_s;
            k_s    = LEN_ZERO;
            st_s   = PAY;
            perr_s = perr_r
                   | ((hdr_dest_s != RX_SEL)  ? ERR_M_DEST   : ERR_NONE)
                   | ((hdr_len_s == LEN_ZERO) ? ERR_M_LENGTH : ERR_NONE);
          end else if (k_r == len_r) begin
            perr_s = perr_r | ERR_M_LENGTH;
          end else begin
            word_inc_s = 1'b1;
            k_s        = k_r + LEN_ONE;
            perr_s     = perr_r | ((rd.rd_data != exp_word_s) ? ERR_M_DATA : ERR_NONE);
          end
        end else if (tmo_r == TMO_LIMIT) begin
          close_s     = 1'b1;
          close_err_s = perr_r | ERR_M_TIMEOUT;
          st_s        = IDLE;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end
      default: begin
        st_s = IDLE;
      end
    endcase
  end

  // FSM and packet-context registers; clr deliberately leaves these alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r   <= IDLE;
      src_r  <= {WIDTH_SEL{1'b0}};
      prio_r <= {WIDTH_PRIORITY{1'b0}};
      len_r  <= LEN_ZERO;
      k_r    <= LEN_ZERO;
      perr_r <= ERR_NONE;
      tmo_r  <= TMO_ZERO;
    end else begin
      st_r   <= st_s;
      src_r  <= src_s;
      prio_r <= prio_s;
      len_r  <= len_s;
      k_r    <= k_s;
      perr_r <= perr_s;
      tmo_r  <= tmo_s;
    end
  end

  // Close pulses, sticky flags and last-packet info.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_flags <= ERR_NONE;
      last_src  <= {WIDTH_SEL{1'b0}};
      last_prio <= {WIDTH_PRIORITY{1'b0}};
    end else begin
      pkt_done <= ok_inc_s;
      pkt_err  <= bad_inc_s;
      if (clr) begin
        err_flags <= ERR_NONE;
        last_src  <= {WIDTH_SEL{1'b0}};
        last_prio <= {WIDTH_PRIORITY{1'b0}};
      end else if (close_s) begin
        err_flags <= err_flags | flag_set_s | close_err_s;
        last_src  <= src_r;
        last_prio <= prio_r;
      end else begin
        err_flags <= err_flags | flag_set_s;
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ok_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(ok_inc_s), .cnt(pkt_ok_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(bad_inc_s), .cnt(pkt_err_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_word_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(word_inc_s), .cnt(word_cnt)
  );

endmodule

// File: doc/recv_check.md
Name: recv_check

Overview:
- Per-port receive checker on one switch egress port: rd_sop/rd_eop/rd_vld/rd_data of top_nxn port RX_PORT.
- Consumes packets generated by send_module instances on the other ports, parses the header word and checks framing, destination, length and payload pattern.
- Exposes per-packet pulses, sticky error flags and saturating counters for VIO/ILA readout in the on-board send/receive test.
- One instance per egress port in the board-level test top.

Parameters:
RX_PORT, 0, index of the egress port this instance checks
PORT_NUB, 4, number of switch ports; WIDTH_SEL = $clog2(PORT_NUB)
DATA_WIDTH, 32, rd_data width
DATA_LENGTH_MAX, 256, maximum payload words; WIDTH_LENGTH = $clog2(DATA_LENGTH_MAX)
PRIORITY, 8, priority levels; WIDTH_PRIORITY = $clog2(PRIORITY)
TIMEOUT_CYC, 4096, idle cycles allowed inside a packet before a timeout error
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  input  1  receive-side clock (250 MHz external clock domain)
rst_n  input  1  reset
clr  input  1  synchronous clear of counters and sticky flags
rd_sop  input  1  start-of-packet pulse from the switch
rd_eop  input  1  end-of-packet pulse
rd_vld  input  1  data-word valid
rd_data  input  DATA_WIDTH  data word
pkt_done  output  1  one-cycle pulse: packet closed with no error
pkt_err  output  1  one-cycle pulse: packet closed or aborted with an error
err_flags  output  5  sticky {timeout, data, length, dest, framing}
pkt_ok_cnt  output  CNT_WIDTH  count of good packets, saturating
pkt_err_cnt  output  CNT_WIDTH  count of bad packets, saturating
word_cnt  output  CNT_WIDTH  count of accepted payload words, saturating
last_src  output  WIDTH_SEL  source port of the last closed packet
last_prio  output  WIDTH_PRIORITY  priority of the last closed packet

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low. All outputs and all state reset to 0, and the FSM resets to IDLE.
- Frame format:
  - rd_sop is a 1-cycle pulse with rd_vld=0.
  - It is followed by rd_vld words: the first is the header, then `length` payload words. rd_vld may drop between words.
  - rd_eop is a 1-cycle pulse with rd_vld=0, after the last payload word.
- Header fields, LSB first:
  - dest [WIDTH_SEL-1:0]
  - priority (next WIDTH_PRIORITY bits)
  - length (next WIDTH_LENGTH bits)
  - src [DATA_WIDTH-1 -: WIDTH_SEL]
  - all other bits are 0.
- Payload word k (k = 0..length-1) must equal {src, zero fill, k[WIDTH_LENGTH-1:0]}. The expected word is compared in full, including zero fill.
- FSM states:
  - IDLE: rd_sop -> HDR.
  - HDR: rd_vld captures src, priority and length into registers. Set a dest error if dest != RX_PORT. Set a length error if length == 0. Go to PAY with k = 0.
  - PAY: rd_vld compares against the expected word and increments k and word_cnt. Any mismatch sets the data error for this packet. rd_vld while k == length sets a length error; the word is not compared or counted. rd_eop with k != length sets a length error. rd_eop closes the packet and returns to IDLE.
- Framing errors:
  - rd_sop outside IDLE: framing error. The current packet closes as bad and the FSM goes to HDR (resync on the new packet).
  - rd_eop in IDLE or HDR: framing error. Report a bad packet only when in HDR.
  - rd_vld in IDLE: framing error, word ignored, no packet count.
  - rd_sop together with rd_vld in the same cycle: framing error. The sop takes precedence; the word is ignored.
- Timeout: a counter runs in HDR/PAY and reloads on any rd_vld, rd_sop or rd_eop. When it reaches TIMEOUT_CYC, set the timeout error, close the packet as bad and go to IDLE.
- Packet close, registered:
  - pkt_done or pkt_err pulses in the cycle after the closing event (eop, abort or timeout). Latency is 1 cycle.
  - Exactly one of the two pulses fires per closed packet.
  - pkt_ok_cnt or pkt_err_cnt increments in the same cycle as its pulse; last_src and last_prio update in that cycle too.
- err_flags: sticky OR of the per-packet errors. The IDLE-state framing errors set the flag directly.
- Counters saturate at all-ones, with no wrap.
- clr: clears counters, err_flags, last_src and last_prio in the next cycle. It does not affect the FSM or an in-flight packet. If clr coincides with an increment, clr wins.

Decomposition:
- Shared package recv_check_pkg, also used by send_module:
  - header field offsets and widths
  - error bit indices (FRAMING=0, DEST=1, LENGTH=2, DATA=3, TIMEOUT=4)
  - FSM state enum {IDLE, HDR, PAY}
  - function expected_word(src, k)
- One natural sub-module: sat_counter (CNT_WIDTH, inc, clr), instantiated three times.

Test Plan:
1. RX_PORT=2; packet src=1, dest=2, prio=3, length=4 with a correct pattern, contiguous vld -> one cycle after eop: pkt_done=1, pkt_ok_cnt=1, word_cnt=4, last_src=1, last_prio=3, err_flags=0.
2. Same packet with 2-cycle vld gaps between words -> identical result to scenario 1.
3. Header dest=1 on RX_PORT=2, length=2 -> pkt_err pulse, err_flags=5'b00010, pkt_err_cnt=1.
4. length=3 but 4 payload words, then a second packet with length=3 but 2 words -> both closed bad, err_flags[2]=1, pkt_err_cnt=2, word_cnt=5.
5. Payload word 1 = 0x0000_0005 instead of {src,0,1} -> err_flags[3]=1. New sop mid-packet -> err_flags[0]=1 and resync; the next good packet gives pkt_done.
6. sop plus header, then silence for 4096 cycles -> err_flags[4]=1, pkt_err pulse, FSM back in IDLE. Assert rst_n=0 mid-packet -> all outputs 0 immediately. Pulse clr -> counters 0 next cycle.
